// File: rtl/divider_pkg.sv
// Shared types and default widths for the sequential 32/16 restoring divider.
package divider_pkg;

    localparam int DIV_DVD_W  = 32;
    localparam int DIV_DVS_W  = 16;
    localparam int ITER_CNT_W = $clog2(DIV_DVS_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/divider_32by16_seq_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// trial-subtract the divisor (add of the inverted divisor with carry-in 1).
module div_step #(
    parameter int W = 16
) (
    input  logic [W:0]   prem_in,
    input  logic         dvd_bit,
    input  logic [W-1:0] divisor,
    output logic [W:0]   prem_out,
    output logic         q_bit
);

    logic [W+1:0] shifted;
    logic [W+1:0] diff;

    // Difference is kept one bit wider than the partial remainder so its MSB
    // is a reliable sign; the shifted value never exceeds 2*divisor-1.
    always_comb begin
        shifted  = {prem_in, dvd_bit};
        diff     = shifted + {2'b11, ~divisor} + {{(W+1){1'b0}}, 1'b1};
        q_bit    = ~diff[W+1];
        prem_out = q_bit ? diff[W:0] : shifted[W:0];
    end

endmodule

// File: rtl/divider_32by16_seq.sv
// Sequential restoring divider, DVD_W/DVS_W -> DVS_W quotient and remainder,
// one quotient bit per clock behind valid/ready request and response channels.
// Optional macro DIVIDER_EARLY_OUT_EN: finish in CHECK when dividend < divisor.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a request, in_ready high
// CHECK | screen divide-by-zero / overflow (/ early-out), seed partial rem
// RUN   | one restoring iteration per clock, DVS_W iterations
// DONE  | result presented, held until out_ready
module divider_32by16_seq
    import divider_pkg::*;
#(
    parameter int DVD_W = DIV_DVD_W,
    parameter int DVS_W = DIV_DVS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVS_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             busy
);

    localparam int CNT_W = $clog2(DVS_W + 1);

    div_state_t       state_q, state_d;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVS_W:0]   prem_q, prem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DVS_W-1:0] quo_q, quo_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [DVS_W:0]   step_prem;
    logic             step_qbit;

    // Next dividend bit is always the MSB of the (left-shifting) lower half.
    div_step #(.W(DVS_W)) u_step (
        .prem_in  (prem_q),
        .dvd_bit  (dvd_q[DVS_W-1]),
        .divisor  (dvs_q),
        .prem_out (step_prem),
        .q_bit    (step_qbit)
    );

    // State register and datapath flops; reset discards any in-flight division.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update; everything holds unless a state acts on it.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (dvs_q == '0) begin
                    dbz_d   = 1'b1;
                    quo_d   = '1;
                    rem_d   = dvd_q[DVS_W-1:0];
                    state_d = DONE;
                end
`ifdef DIVIDER_EARLY_OUT_EN
                else if ((dvd_q[DVD_W-1:DVS_W] == '0) && (dvd_q[DVS_W-1:0] < dvs_q)) begin
                    quo_d   = '0;
                    rem_d   = dvd_q[DVS_W-1:0];
                    state_d = DONE;
                end
`endif
                else if (dvd_q[DVD_W-1:DVS_W] >= dvs_q) begin
                    ovf_d   = 1'b1;
                    quo_d   = '1;
                    rem_d   = dvd_q[DVS_W-1:0];
                    state_d = DONE;
                end else begin
                    // Upper half < divisor guarantees the quotient fits.
                    prem_d  = {1'b0, dvd_q[DVD_W-1:DVS_W]};
                    cnt_d   = CNT_W'(DVS_W);
                    state_d = RUN;
                end
            end
            RUN: begin
                prem_d = step_prem;
                dvd_d  = {dvd_q[DVD_W-2:0], 1'b0};
                quo_d  = {quo_q[DVS_W-2:0], step_qbit};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rem_d   = step_prem[DVS_W-1:0];
                    state_d = DONE;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_divider_32by16_seq.sv
// Self-checking bench for divider_32by16_seq: directed cases, stall, mid-run
// reset, back-to-back throughput and randomized operands against a model.
module tb_divider_32by16_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    divider_32by16_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .busy        (busy)
    );

    // Behavioural reference: plain integer division plus the flag rules.
    function automatic void ref_div(input logic [31:0] a, input logic [15:0] b,
                                    output logic [15:0] q, output logic [15:0] r,
                                    output logic dz, output logic ov, output int lat);
        logic [31:0] qq;
        dz  = 1'b0;
        ov  = 1'b0;
        lat = 17;
        if (b == 16'd0) begin
            dz = 1'b1; q = 16'hFFFF; r = a[15:0]; lat = 1;
        end else begin
            qq = a / {16'd0, b};
            if (qq > 32'h0000_FFFF) begin
                ov = 1'b1; q = 16'hFFFF; r = a[15:0]; lat = 1;
            end else begin
                q = qq[15:0];
                r = 16'(a % {16'd0, b});
`ifdef DIVIDER_EARLY_OUT_EN
                if (a < {16'd0, b}) lat = 1;
`endif
            end
        end
    endfunction

    // Drive one request and count edges from accept until out_valid (bounded).
    task automatic issue(input logic [31:0] a, input logic [15:0] b, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        dividend = '0; divisor = '0;
        #2;
        n_cmp++;
        if ({out_valid, quotient, remainder, div_by_zero, overflow, busy, in_ready} !== {1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got ov=%b q=%h r=%h dz=%b of=%b busy=%b rdy=%b want all 0, rdy=1",
                     out_valid, quotient, remainder, div_by_zero, overflow, busy, in_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [4] = '{32'd1000, 32'h0000_1234, 32'h0001_0000, 32'd5};
        logic [15:0] tb_ [4] = '{16'd7, 16'h0000, 16'h0001, 16'd9};
        logic [15:0] eq [4] = '{16'd142, 16'hFFFF, 16'hFFFF, 16'd0};
        logic [15:0] er [4] = '{16'd6, 16'h1234, 16'h0000, 16'd5};
        logic [1:0]  ef [4] = '{2'b00, 2'b10, 2'b01, 2'b00};
`ifdef DIVIDER_EARLY_OUT_EN
        int el [4] = '{17, 1, 1, 1};
`else
        int el [4] = '{17, 1, 1, 17};
`endif
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb_[i], lat);
            n_cmp++;
            if (lat !== el[i]) begin
                n_err++;
                $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, el[i]);
            end
            n_cmp++;
            if ({quotient, remainder, div_by_zero, overflow} !== {eq[i], er[i], ef[i]}) begin
                n_err++;
                $display("FAIL directed_result[%0d]: got q=%h r=%h dz=%b of=%b want q=%h r=%h flags=%b",
                         i, quotient, remainder, div_by_zero, overflow, eq[i], er[i], ef[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        int lat;
        out_ready = 1'b0;
        issue(32'hFFFE_0001, 16'hFFFF, lat);
        n_cmp++;
        if ({lat == 17, quotient, remainder, div_by_zero, overflow} !== {1'b1, 16'hFFFF, 16'h0000, 2'b00}) begin
            n_err++;
            $display("FAIL stall_result: got lat=%0d q=%h r=%h dz=%b of=%b want lat=17 q=ffff r=0000 flags=00",
                     lat, quotient, remainder, div_by_zero, overflow);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, in_ready, busy, quotient, remainder, div_by_zero, overflow} !== {3'b101, 16'hFFFF, 16'h0000, 2'b00}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got ov=%b rdy=%b busy=%b q=%h r=%h want ov=1 rdy=0 busy=1 q=ffff r=0000",
                         k, out_valid, in_ready, busy, quotient, remainder);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, in_ready, busy, quotient, remainder} !== {3'b010, 16'hFFFF, 16'h0000}) begin
            n_err++;
            $display("FAIL stall_release: got ov=%b rdy=%b busy=%b q=%h r=%h want ov=0 rdy=1 busy=0 q=ffff r=0000",
                     out_valid, in_ready, busy, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; dividend = 32'd100000; divisor = 16'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, quotient, remainder, div_by_zero, overflow, busy} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_mid_run: got ov=%b q=%h r=%h dz=%b of=%b busy=%b want all 0",
                     out_valid, quotient, remainder, div_by_zero, overflow, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold_valid: got %b want 0", out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        issue(32'd100, 16'd10, lat);
        n_cmp++;
        if ({lat == 17, quotient, remainder, div_by_zero, overflow} !== {1'b1, 16'd10, 16'd0, 2'b00}) begin
            n_err++;
            $display("FAIL reset_fresh_request: got lat=%0d q=%0d r=%0d dz=%b of=%b want lat=17 q=10 r=0 flags=00",
                     lat, quotient, remainder, div_by_zero, overflow);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [2] = '{32'd123456, 32'hDEAD_BEEF};
        logic [15:0] b [2] = '{16'd789, 16'hF00D};
        logic [15:0] eq, er;
        logic        edz, eov;
        int          elat;
        int          hit_cyc [2];
        int          hits = 0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; dividend = a[0]; divisor = b[0];
        for (int cyc = 1; cyc <= 100 && hits < 2; cyc++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                hit_cyc[hits] = cyc;
                ref_div(a[hits], b[hits], eq, er, edz, eov, elat);
                n_cmp++;
                if ({quotient, remainder, div_by_zero, overflow, in_ready} !== {eq, er, edz, eov, 1'b0}) begin
                    n_err++;
                    $display("FAIL b2b_result[%0d]: got q=%h r=%h dz=%b of=%b rdy=%b want q=%h r=%h dz=%b of=%b rdy=0",
                             hits, quotient, remainder, div_by_zero, overflow, in_ready, eq, er, edz, eov);
                end
                hits++;
                @(negedge clk);
                if (hits == 1) begin
                    dividend = a[1]; divisor = b[1];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (hits != 2 || (hit_cyc[1] - hit_cyc[0]) != 19) begin
            n_err++;
            $display("FAIL b2b_throughput: got hits=%0d gap=%0d want hits=2 gap=19",
                     hits, (hits == 2) ? hit_cyc[1] - hit_cyc[0] : -1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [15:0] b, q, r, eq, er;
        logic        edz, eov;
        int          elat, lat, mode, stall;
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 9);
            b = 16'($urandom_range(1, 16'hFFFF));
            case (mode)
                0: begin b = 16'd0; a = $urandom; end
                1: a = {16'(b + 16'($urandom_range(0, 16'hFFFF - b))), 16'($urandom)};
                2: a = {16'd0, 16'($urandom_range(0, b - 1))};
                default: begin
                    q = 16'($urandom);
                    r = 16'($urandom_range(0, b - 1));
                    a = {16'd0, q} * {16'd0, b} + {16'd0, r};
                end
            endcase
            ref_div(a, b, eq, er, edz, eov, elat);
            stall = $urandom_range(0, 3);
            out_ready = (stall == 0);
            issue(a, b, lat);
            n_cmp++;
            if (lat !== elat || {quotient, remainder, div_by_zero, overflow} !== {eq, er, edz, eov}) begin
                n_err++;
                $display("FAIL random[%0d] %h/%h: got lat=%0d q=%h r=%h dz=%b of=%b want lat=%0d q=%h r=%h dz=%b of=%b",
                         i, a, b, lat, quotient, remainder, div_by_zero, overflow, elat, eq, er, edz, eov);
            end
            if (stall != 0) begin
                repeat (stall) @(posedge clk);
                #1;
                n_cmp++;
                if ({out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, eq, er, edz, eov}) begin
                    n_err++;
                    $display("FAIL random_stall[%0d]: got ov=%b q=%h r=%h want ov=1 q=%h r=%h",
                             i, out_valid, quotient, remainder, eq, er);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
